// File: rtl/sweep_pkg.sv
// ============================================================================
// sweep_pkg : shared state encoding and default widths for the sweep controller
// Rev 1.0
// ============================================================================
`default_nettype none

package sweep_pkg;

  localparam int COUNTER_WIDTH_DEF = 8;
  localparam int DIV_WIDTH_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_e;

endpackage

`default_nettype wire

// File: rtl/sweep_prescaler.sv
// ============================================================================
// sweep_prescaler : step-rate divider, one tick every (div + 1) running cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module sweep_prescaler
  import sweep_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic                 at_end;

  assign at_end = (cnt_q == div);

  // Clear wins over run so the first running cycle always starts from zero.
  assign tick = run && !clr && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      if (at_end) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sweep_ctrl.sv
// ============================================================================
// sweep_ctrl : run controller for a bouncing shift register sweep
// Rev 1.0
// ============================================================================
`default_nettype none

module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
  parameter int DIV_WIDTH     = DIV_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic [DIV_WIDTH-1:0]     div_val,
  input  logic [COUNTER_WIDTH-1:0] n_sweeps,
  input  logic                     tc_in,
  output logic                     shift_ena,
  output logic                     shreg_rstna,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [COUNTER_WIDTH-1:0] sweep_cnt
);

  sweep_state_e             state_q,     state_d;
  logic [DIV_WIDTH-1:0]     div_q,       div_d;
  logic [COUNTER_WIDTH-1:0] target_q,    target_d;
  logic [COUNTER_WIDTH-1:0] cnt_q,       cnt_d;
  logic                     shift_ena_q, shift_ena_d;
  logic                     aborted_q,   aborted_d;

  logic [COUNTER_WIDTH-1:0] cnt_inc;
  logic                     active;
  logic                     reached;
  logic                     presc_tick;

  assign cnt_inc = cnt_q + COUNTER_WIDTH'(1);
  assign active  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign reached = tc_in && (target_q != '0) && (cnt_inc == target_q);

  // The divider advances on every cycle that ends in RUN, including resume.
  sweep_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (state_d == ST_RUN),
    .clr  (state_q == ST_CLEAR),
    .div  (div_q),
    .tick (presc_tick)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CLEAR;
          div_d    = div_val;
          target_d = n_sweeps;
          cnt_d    = '0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
      end
      ST_RUN, ST_PAUSE: begin
        if (tc_in) begin
          cnt_d = cnt_inc;
        end
        // Abort outranks completion, which outranks pause handling.
        if (stop) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (reached) begin
          state_d = ST_DONE;
        end else if ((state_q == ST_RUN) && pause) begin
          state_d = ST_PAUSE;
        end else if ((state_q == ST_PAUSE) && !pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    shift_ena_d = presc_tick && (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      shift_ena_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      shift_ena_q <= shift_ena_d;
      aborted_q   <= aborted_d;
    end
  end

  assign shift_ena   = shift_ena_q;
  assign shreg_rstna = (state_q != ST_CLEAR);
  assign busy        = active;
  assign done        = (state_q == ST_DONE);
  assign aborted     = aborted_q;
  assign sweep_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sweep_ctrl.sv
// ============================================================================
// tb_sweep_ctrl : directed self-checking bench for sweep_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] div_val = '0;
  logic [7:0]  n_sweeps = '0;
  logic        tc_drv = 1'b0;
  logic        use_model = 1'b0;
  logic        tc_in;
  logic        shift_ena;
  logic        shreg_rstna;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  sweep_cnt;

  int checks = 0;
  int errors = 0;
  int se_total = 0;

  // 8-bit bounce register model: one end-of-sweep pulse per 7 steps.
  logic [2:0] pos = '0;
  logic       tc_model = 1'b0;

  assign tc_in = use_model ? tc_model : tc_drv;

  sweep_ctrl #(
    .COUNTER_WIDTH (8),
    .DIV_WIDTH     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .div_val     (div_val),
    .n_sweeps    (n_sweeps),
    .tc_in       (tc_in),
    .shift_ena   (shift_ena),
    .shreg_rstna (shreg_rstna),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .sweep_cnt   (sweep_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tc_model <= 1'b0;
    if (shreg_rstna === 1'b0) begin
      pos <= '0;
    end else if (shift_ena === 1'b1) begin
      if (pos == 3'd6) begin
        pos      <= '0;
        tc_model <= 1'b1;
      end else begin
        pos <= pos + 3'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (shift_ena === 1'b1) se_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int se_base;
    logic seen;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_shift_ena", {31'd0, shift_ena}, 0);
    check("rst_shreg_rstna", {31'd0, shreg_rstna}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_aborted", {31'd0, aborted}, 0);
    check("rst_sweep_cnt", {24'd0, sweep_cnt}, 0);

    // Stop in IDLE is ignored
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle_stop_done", {31'd0, done}, 0);
    check("idle_stop_aborted", {31'd0, aborted}, 0);

    // Three sweeps with div 2, tc from the bounce model
    use_model = 1'b1;
    div_val   = 16'd2;
    n_sweeps  = 8'd3;
    se_base   = se_total;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("a_clear_rstna", {31'd0, shreg_rstna}, 0);
    check("a_clear_shift", {31'd0, shift_ena}, 0);
    check("a_clear_busy", {31'd0, busy}, 0);
    tick();
    check("a_run_rstna", {31'd0, shreg_rstna}, 1);
    check("a_run_busy", {31'd0, busy}, 1);
    tick();
    check("a_first_se_c1", {31'd0, shift_ena}, 0);
    tick();
    check("a_first_se_c2", {31'd0, shift_ena}, 0);
    tick();
    check("a_first_se_c3", {31'd0, shift_ena}, 1);
    tick();
    check("a_period_c1", {31'd0, shift_ena}, 0);
    tick();
    check("a_period_c2", {31'd0, shift_ena}, 0);
    tick();
    check("a_period_c3", {31'd0, shift_ena}, 1);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("a_done", {31'd0, done}, 1);
    check("a_aborted", {31'd0, aborted}, 0);
    check("a_sweep_cnt", {24'd0, sweep_cnt}, 3);
    check("a_shift_total", se_total - se_base, 21);
    check("a_done_shift", {31'd0, shift_ena}, 0);
    use_model = 1'b0;
    tick();
    check("a_idle_done", {31'd0, done}, 0);
    check("a_idle_busy", {31'd0, busy}, 0);
    tick();
    check("a_idle_hold_cnt", {24'd0, sweep_cnt}, 3);

    // Reset mid-run; start while running is ignored
    div_val  = 16'd5;
    n_sweeps = 8'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tc_drv = 1'b1;
    tick();
    tick();
    tc_drv = 1'b0;
    check("b_cnt_before", {24'd0, sweep_cnt}, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b_start_ign_busy", {31'd0, busy}, 1);
    check("b_start_ign_rstna", {31'd0, shreg_rstna}, 1);
    check("b_start_ign_cnt", {24'd0, sweep_cnt}, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("b_rst_busy", {31'd0, busy}, 0);
    check("b_rst_shift", {31'd0, shift_ena}, 0);
    check("b_rst_cnt", {24'd0, sweep_cnt}, 0);
    check("b_rst_rstna", {31'd0, shreg_rstna}, 1);
    check("b_rst_done", {31'd0, done}, 0);
    div_val = 16'd4;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("b_clear_low", {31'd0, shreg_rstna}, 0);
    tick();
    check("b_clear_one_cycle", {31'd0, shreg_rstna}, 1);

    // Pause held 10 cycles with the divider at 1 (div 4)
    n = 0;
    while (shift_ena !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("c_se_wait", {31'd0, shift_ena}, 1);
    tick();
    pause = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (shift_ena !== 1'b0) seen = 1'b1;
    end
    check("c_pause_no_shift", {31'd0, seen}, 0);
    check("c_pause_busy", {31'd0, busy}, 1);
    pause = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (shift_ena !== 1'b0) seen = 1'b1;
    end
    check("c_resume_gap", {31'd0, seen}, 0);
    tick();
    check("c_resume_shift", {31'd0, shift_ena}, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("c_stop_done", {31'd0, done}, 1);
    check("c_stop_aborted", {31'd0, aborted}, 1);
    tick();

    // Free-run, 600 sweeps wrap the 8-bit count to 88, then stop
    div_val  = 16'd0;
    n_sweeps = 8'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tc_drv = 1'b1;
    repeat (600) tick();
    tc_drv = 1'b0;
    check("d_cnt_wrap", {24'd0, sweep_cnt}, 88);
    check("d_still_busy", {31'd0, busy}, 1);
    check("d_shift_every", {31'd0, shift_ena}, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("d_done", {31'd0, done}, 1);
    check("d_aborted", {31'd0, aborted}, 1);
    check("d_final_cnt", {24'd0, sweep_cnt}, 88);
    tick();
    check("d_done_clear", {31'd0, done}, 0);
    check("d_aborted_clear", {31'd0, aborted}, 0);

    // Stop coincident with the final target tc
    div_val  = 16'd1;
    n_sweeps = 8'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tc_drv = 1'b1;
    tick();
    tc_drv = 1'b0;
    check("e_cnt_one", {24'd0, sweep_cnt}, 1);
    tick();
    tc_drv = 1'b1;
    stop   = 1'b1;
    tick();
    tc_drv = 1'b0;
    stop   = 1'b0;
    check("e_cnt_two", {24'd0, sweep_cnt}, 2);
    check("e_done", {31'd0, done}, 1);
    check("e_aborted", {31'd0, aborted}, 1);
    tick();
    check("e_idle_busy", {31'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 8, width of sweep target and sweep count.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of step-rate divider.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request; begins a sweep run.
REQ-006 SHALL have port stop  input  1  aborts a run in RUN or PAUSE.
REQ-007 SHALL have port pause  input  1  level; holds stepping while high.
REQ-008 SHALL have port div_val  input  DIV_WIDTH  step interval minus one, in clk cycles; sampled on start.
REQ-009 SHALL have port n_sweeps  input  COUNTER_WIDTH  target sweep count; 0 = free-run until stop; sampled on start.
REQ-010 SHALL have port tc_in  input  1  end-of-sweep pulse from the bouncing shift register.
REQ-011 SHALL have port shift_ena  output  1  step enable to the shift register.
REQ-012 SHALL have port shreg_rstna  output  1  active-low clear to the shift register.
REQ-013 SHALL have port busy  output  1  high in RUN and PAUSE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on completion or abort.
REQ-015 SHALL have port aborted  output  1  one-cycle pulse, coincident with done, only when ended by stop.
REQ-016 SHALL have port sweep_cnt  output  COUNTER_WIDTH  sweeps completed in current/last run.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, RUN, PAUSE, DONE.
REQ-018 IDLE: start=1 -> CLEAR; latch div_val, n_sweeps; sweep_cnt cleared to 0.
REQ-019 CLEAR: lasts exactly one cycle; shreg_rstna=0; shift_ena=0; then -> RUN.
REQ-020 RUN: prescaler counts 0..div_latched; shift_ena=1 for one cycle when count==div_latched, count then wraps to 0.
REQ-021 div_latched=0 SHALL give shift_ena=1 every RUN cycle; first shift_ena occurs div_latched+1 cycles after entering RUN.
REQ-022 tc_in=1 in RUN or PAUSE SHALL increment sweep_cnt by 1; tc_in ignored in IDLE, CLEAR, DONE.
REQ-023 Free-run (n_sweeps=0): sweep_cnt SHALL wrap from 2^COUNTER_WIDTH-1 to 0; no completion.
REQ-024 n_sweeps>0: on the cycle sweep_cnt+tc_in reaches n_sweeps, SHALL go RUN -> DONE; shift_ena=0 from the next cycle.
REQ-025 RUN with pause=1 -> PAUSE; PAUSE with pause=0 -> RUN; prescaler count held, shift_ena=0 in PAUSE.
REQ-026 stop=1 in RUN or PAUSE -> DONE with aborted pulse; stop has priority over pause and completion in the same cycle; a coincident tc_in is still counted.
REQ-027 DONE: lasts one cycle; done=1; -> IDLE.
REQ-028 start SHALL be ignored outside IDLE; stop ignored in IDLE, CLEAR, DONE.
REQ-029 shift_ena SHALL be registered and only asserted in RUN.
REQ-030 sweep_cnt SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-031 rst=1 SHALL force IDLE in the same edge, including mid-run.
REQ-032 Reset values: shift_ena=0, shreg_rstna=1, busy=0, done=0, aborted=0, sweep_cnt=0, prescaler=0, latched div/target=0.

Structure
REQ-033 State encoding and default widths SHALL live in shared package sweep_pkg.
REQ-034 Prescaler SHALL be sub-module sweep_prescaler (inputs clk, rst, run, clr, div; output tick).
REQ-035 Target: 120-400 lines RTL; no latches, no combinational outputs except from registered state.

Verification
REQ-036 div_val=2, n_sweeps=3, model tc_in from 8-bit bounce register -> shift_ena every 3rd cycle; done after 3rd tc_in; sweep_cnt=3; aborted=0.
REQ-037 div_val=0, n_sweeps=0, run 600 tc_in pulses then stop -> sweep_cnt=88 (600 mod 256); done and aborted pulse together.
REQ-038 pause high 10 cycles mid-interval at prescaler=1, div_val=4 -> no shift_ena in pause; next shift_ena 3 cycles after pause drops.
REQ-039 stop and tc_in same cycle as final target sweep (n_sweeps=2) -> sweep_cnt=2, aborted=1, done=1.
REQ-040 rst asserted in RUN -> next cycle all outputs at reset values; start in RUN ignored; start after reset -> shreg_rstna low exactly one cycle.
